rr_encoder: RTL and testbench

- Sequential round-robin one-hot/multi-hot-to-binary encoder; the inverse of the binary-to-one-hot decoders used in the lab designs.
- Samples a request vector and picks one set bit using rotating priority, so no requester starves.
- Registers the selected index and presents it on a ready/valid output.
- Used wherever several cells or units compete for a shared resource and a binary select is needed downstream.

---
 rtl/rr_encoder_pkg.sv | 10 +
 rtl/rr_encoder_if.sv | 33 +++
 rtl/rr_priority_pick.sv | 32 +++
 rtl/rr_encoder.sv | 91 +++++++++
 tb/tb_rr_encoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rr_encoder_pkg.sv
// Shared types for the round-robin encoder.
// Only the FSM state lives here; widths are derived per module.
package rr_encoder_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/rr_encoder_if.sv
// Request/grant bundle for rr_encoder.
// master drives requests and ready, slave returns the grant.
interface rr_encoder_if #(
  parameter int N = 4
) ();
  localparam int W = $clog2(N);

  logic         ena;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_index;
  logic [N-1:0] out_onehot;

  modport master (
    output ena,
    output req,
    output out_ready,
    input  out_valid,
    input  out_index,
    input  out_onehot
  );

  modport slave (
    input  ena,
    input  req,
    input  out_ready,
    output out_valid,
    output out_index,
    output out_onehot
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Rotating-priority search over req starting at start.
// Wrap is modulo N, so N need not be a power of two.
module rr_priority_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] win
);

  logic [2*N-1:0] dbl;

  assign dbl = {req, req};

  // Scan the doubled vector for N bits from start.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && dbl[int'(start) + k]) begin
        found = 1'b1;
        if (int'(start) + k >= N)
          win = W'(int'(start) + k - N);
        else
          win = W'(int'(start) + k);
      end
    end
  end

endmodule

// File: rtl/rr_encoder.sv
// Round-robin multi-hot to binary encoder with a
// registered ready/valid grant output.
module rr_encoder
  import rr_encoder_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  rr_encoder_if.slave  bus
);

  localparam int W = $clog2(N);

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] ptr_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] oh_q;
  logic [W-1:0] nxt_ptr;
  logic [W-1:0] start;
  logic         found;
  logic [W-1:0] win;
  logic         hs;
  logic         cap;

  assign nxt_ptr = (idx_q == W'(N - 1)) ? '0
                                        : idx_q + 1'b1;

  // On a handshake search from the post-accept pointer.
  assign start = (state_q == S_HOLD) ? nxt_ptr : ptr_q;

  assign hs  = (state_q == S_HOLD) && bus.out_ready;
  assign cap = bus.ena && found &&
               ((state_q == S_IDLE) || hs);

  rr_priority_pick #(
    .N (N)
  ) u_pick (
    .req   (bus.req),
    .start (start),
    .found (found),
    .win   (win)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (cap)
          state_d = S_HOLD;
      end
      (state_q == S_HOLD): begin
        if (hs && !cap)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      idx_q <= '0;
      oh_q  <= '0;
    end else begin
      if (hs)
        ptr_q <= nxt_ptr;
      if (cap) begin
        idx_q <= win;
        oh_q  <= {{(N-1){1'b0}}, 1'b1} << win;
      end else if (hs) begin
        oh_q  <= '0;
      end
    end
  end

  always_comb begin
    bus.out_valid  = (state_q == S_HOLD);
    bus.out_index  = idx_q;
    bus.out_onehot = oh_q;
  end

endmodule

// File: tb/tb_rr_encoder.sv
// Self-checking bench for rr_encoder with N=4:
// per-cycle vector table, scoreboard queue, hand sequences.
module tb_rr_encoder;

  typedef struct {
    logic       rst;
    logic       ena;
    logic [3:0] req;
    logic       rdy;
    logic       ev;
    logic [1:0] ei;
    logic [3:0] eo;
  } vec_t;

  typedef struct {
    logic       v;
    logic [1:0] i;
    logic [3:0] o;
  } exp_t;

  logic clk;
  logic rst;

  rr_encoder_if #(.N(4)) bus ();

  rr_encoder #(
    .N (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tbl[$];
  exp_t sb[$];
  int   npass;
  int   ntot;

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    ntot++;
    if (act == exp)
      npass++;
    else
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
  endtask

  task automatic add(input logic r, input logic e,
                     input logic [3:0] q,
                     input logic y, input logic v,
                     input logic [1:0] i,
                     input logic [3:0] o);
    vec_t t;
    t.rst = r; t.ena = e; t.req = q; t.rdy = y;
    t.ev = v; t.ei = i; t.eo = o;
    tbl.push_back(t);
  endtask

  task automatic step(input vec_t t, input int n);
    exp_t x;
    exp_t g;
    rst           = t.rst;
    bus.ena       = t.ena;
    bus.req       = t.req;
    bus.out_ready = t.rdy;
    x.v = t.ev; x.i = t.ei; x.o = t.eo;
    sb.push_back(x);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check($sformatf("v%0d.valid", n),
          int'(bus.out_valid), int'(g.v));
    check($sformatf("v%0d.index", n),
          int'(bus.out_index), int'(g.i));
    check($sformatf("v%0d.onehot", n),
          int'(bus.out_onehot), int'(g.o));
  endtask

  task automatic drive(input logic e,
                       input logic [3:0] q,
                       input logic y);
    rst           = 1'b0;
    bus.ena       = e;
    bus.req       = q;
    bus.out_ready = y;
  endtask

  initial begin
    int cnt;
    npass = 0;
    ntot  = 0;
    rst           = 1'b1;
    bus.ena       = 1'b1;
    bus.req       = 4'b1111;
    bus.out_ready = 1'b0;

    // reset, first grant after release
    add(1, 1, 4'b1111, 0, 0, 0, 4'b0000);
    add(1, 1, 4'b1111, 0, 0, 0, 4'b0000);
    add(0, 1, 4'b1111, 0, 1, 0, 4'b0001);
    add(0, 1, 4'b0000, 1, 0, 0, 4'b0000);
    // round robin over 1010
    add(0, 1, 4'b1010, 1, 1, 1, 4'b0010);
    add(0, 1, 4'b1010, 1, 1, 3, 4'b1000);
    add(0, 1, 4'b1010, 1, 1, 1, 4'b0010);
    add(0, 1, 4'b1010, 1, 1, 3, 4'b1000);
    add(0, 1, 4'b0000, 1, 0, 3, 4'b0000);
    // backpressure, req drops while held
    add(0, 1, 4'b0110, 0, 1, 1, 4'b0010);
    add(0, 1, 4'b0110, 0, 1, 1, 4'b0010);
    add(0, 1, 4'b0000, 0, 1, 1, 4'b0010);
    add(0, 1, 4'b0000, 0, 1, 1, 4'b0010);
    add(0, 1, 4'b0000, 0, 1, 1, 4'b0010);
    add(0, 1, 4'b0000, 0, 1, 1, 4'b0010);
    add(0, 1, 4'b0000, 1, 0, 1, 4'b0000);
    // wrap from index 3
    add(0, 1, 4'b1000, 0, 1, 3, 4'b1000);
    add(0, 1, 4'b1111, 1, 1, 0, 4'b0001);
    add(0, 1, 4'b1111, 1, 1, 1, 4'b0010);
    add(0, 1, 4'b1111, 1, 1, 2, 4'b0100);
    add(0, 1, 4'b1111, 1, 1, 3, 4'b1000);
    add(0, 1, 4'b1111, 1, 1, 0, 4'b0001);
    add(0, 1, 4'b0000, 1, 0, 0, 4'b0000);
    // enable gating
    add(0, 0, 4'b1111, 0, 0, 0, 4'b0000);
    add(0, 0, 4'b1111, 0, 0, 0, 4'b0000);
    add(0, 0, 4'b1111, 0, 0, 0, 4'b0000);
    add(0, 0, 4'b1111, 0, 0, 0, 4'b0000);
    add(0, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 1, 4'b0100, 0, 1, 2, 4'b0100);
    // reset beats a handshake, ptr back to 0
    add(1, 1, 4'b1111, 1, 0, 0, 4'b0000);
    add(0, 1, 4'b1111, 0, 1, 0, 4'b0001);
    // ena low on handshake returns to idle
    add(0, 0, 4'b1111, 1, 0, 0, 4'b0000);
    // single requester every cycle
    add(0, 1, 4'b0001, 1, 1, 0, 4'b0001);
    add(0, 1, 4'b0001, 1, 1, 0, 4'b0001);
    add(0, 1, 4'b0001, 1, 1, 0, 4'b0001);
    add(0, 1, 4'b0001, 1, 1, 0, 4'b0001);

    for (int n = 0; n < tbl.size(); n++)
      step(tbl[n], n);

    // bounded wait for a fresh grant
    drive(1'b0, 4'b1111, 1'b1);
    @(posedge clk);
    #1;
    check("drop.valid", int'(bus.out_valid), 0);
    drive(1'b1, 4'b0010, 1'b0);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!bus.out_valid && cnt < 5);
    check("lat.cycles", cnt, 1);
    check("lat.valid", int'(bus.out_valid), 1);
    check("lat.index", int'(bus.out_index), 1);

    // frozen while held with ena low
    drive(1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("frz%0d.valid", k),
            int'(bus.out_valid), 1);
      check($sformatf("frz%0d.index", k),
            int'(bus.out_index), 1);
    end

    // lone requester regranted across wrap
    drive(1'b1, 4'b0010, 1'b1);
    @(posedge clk);
    #1;
    check("re.valid", int'(bus.out_valid), 1);
    check("re.index", int'(bus.out_index), 1);
    check("re.onehot", int'(bus.out_onehot), 2);

    check("sb.empty", sb.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
